// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the data memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int SEL_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_RD   = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_if
//  Description : CPU, readout and memory-side signals of the data memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_rvalid;
    logic [7:0]        rd_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, rd_req, rd_addr, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, rd_gnt, rd_rvalid, rd_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, rd_req, rd_addr, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, rd_gnt, rd_rvalid, rd_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_byte_lane_sel.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_sel
//  Description : Little-endian byte extraction from a 32-bit word.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_lane_sel
    import mem_arb_pkg::*;
(
    input  wire logic [BYTES_PER_WORD*8-1:0] i_word,
    input  wire logic [SEL_W-1:0]            i_sel,
    output logic      [7:0]                  o_byte
);

    always_comb begin
        o_byte = i_word[7:0];
        case (i_sel)
            2'd0:    o_byte = i_word[7:0];
            2'd1:    o_byte = i_word[15:8];
            2'd2:    o_byte = i_word[23:16];
            2'd3:    o_byte = i_word[31:24];
            default: o_byte = i_word[7:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : CPU-priority arbiter with readout anti-starvation for a
//                single-port sync-read data memory; routes read responses.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    data_mem_arbiter_if.slave bus
);

    localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

    owner_t              r_owner;
    owner_t              w_ownerNext;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic [c_WAIT_W-1:0] w_waitCntNext;
    logic [SEL_W-1:0]    r_byteSel;
    logic [SEL_W-1:0]    w_byteSelNext;
    logic [DATA_W-1:0]   r_cpuRdata;
    logic [7:0]          r_rdRdata;

    logic                w_cpuWin;
    logic                w_rdWin;
    logic [7:0]          w_laneByte;
    logic                w_unusedCpuAddrLsb;

    logic                w_memEn;
    logic                w_memWe;
    logic [ADDR_W-3:0]   w_memAddr;
    logic [DATA_W-1:0]   w_memWdata;
    logic                w_cpuRvalid;
    logic [DATA_W-1:0]   w_cpuRdata;
    logic                w_rdRvalid;
    logic [7:0]          w_rdRdata;

    // Readout takes the slot when alone, or when it has waited MAX_WAIT cycles.
    assign w_rdWin  = bus.rd_req && (!bus.cpu_req || (r_waitCnt == c_WAIT_MAX));
    assign w_cpuWin = bus.cpu_req && !w_rdWin;

    assign w_unusedCpuAddrLsb = ^bus.cpu_addr[1:0];

    byte_lane_sel u_byteLaneSel (
        .i_word (bus.mem_rdata),
        .i_sel  (r_byteSel),
        .o_byte (w_laneByte)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= OWN_NONE;
            r_waitCnt  <= '0;
            r_byteSel  <= '0;
            r_cpuRdata <= '0;
            r_rdRdata  <= '0;
        end else begin
            r_owner   <= w_ownerNext;
            r_waitCnt <= w_waitCntNext;
            r_byteSel <= w_byteSelNext;
            if (r_owner == OWN_CPU) begin
                r_cpuRdata <= bus.mem_rdata;
            end
            if (r_owner == OWN_RD) begin
                r_rdRdata <= w_laneByte;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_ownerNext   = OWN_NONE;
        w_waitCntNext = '0;
        w_byteSelNext = r_byteSel;

        if (w_cpuWin && !bus.cpu_we) begin
            w_ownerNext = OWN_CPU;
        end else if (w_rdWin) begin
            w_ownerNext   = OWN_RD;
            w_byteSelNext = bus.rd_addr[SEL_W-1:0];
        end

        if (bus.rd_req && !w_rdWin) begin
            w_waitCntNext = (r_waitCnt == c_WAIT_MAX) ? r_waitCnt
                                                      : r_waitCnt + c_WAIT_W'(1);
        end
    end

    // Output logic: memory drive and response routing
    always_comb begin
        w_memEn    = w_cpuWin || w_rdWin;
        w_memWe    = w_cpuWin && bus.cpu_we;
        w_memAddr  = '0;
        w_memWdata = '0;
        if (w_cpuWin) begin
            w_memAddr  = bus.cpu_addr[ADDR_W-1:2];
            w_memWdata = bus.cpu_wdata;
        end else if (w_rdWin) begin
            w_memAddr  = bus.rd_addr[ADDR_W-1:2];
        end

        // Read data passes straight through on the response cycle, held otherwise.
        w_cpuRvalid = (r_owner == OWN_CPU);
        w_rdRvalid  = (r_owner == OWN_RD);
        w_cpuRdata  = w_cpuRvalid ? bus.mem_rdata : r_cpuRdata;
        w_rdRdata   = w_rdRvalid  ? w_laneByte    : r_rdRdata;
    end

    assign bus.cpu_gnt    = w_cpuWin;
    assign bus.rd_gnt     = w_rdWin;
    assign bus.mem_en     = w_memEn;
    assign bus.mem_we     = w_memWe;
    assign bus.mem_addr   = w_memAddr;
    assign bus.mem_wdata  = w_memWdata;
    assign bus.cpu_rvalid = w_cpuRvalid;
    assign bus.cpu_rdata  = w_cpuRdata;
    assign bus.rd_rvalid  = w_rdRvalid;
    assign bus.rd_rdata   = w_rdRdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Directed self-checking bench for data_mem_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read single-port memory
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata    <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cReq, input logic cWe, input logic [7:0] cAddr,
                         input logic [31:0] cData, input logic rReq, input logic [7:0] rAddr);
        bus.cpu_req   = cReq;
        bus.cpu_we    = cWe;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = cData;
        bus.rd_req    = rReq;
        bus.rd_addr   = rAddr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] expBytes [0:3];
        logic       prevCpu;
        expBytes[0] = 8'hEF;
        expBytes[1] = 8'hBE;
        expBytes[2] = 8'hAD;
        expBytes[3] = 8'hDE;

        rst           = 1'b0;
        bus.mem_rdata = '0;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        #2;
        chk("rst_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        chk("rst_rd_rvalid",  {31'b0, bus.rd_rvalid},  32'd0);
        chk("rst_cpu_rdata",  bus.cpu_rdata,           32'd0);
        chk("rst_rd_rdata",   {24'b0, bus.rd_rdata},   32'd0);
        cyc();
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle", {27'b0, bus.cpu_gnt, bus.rd_gnt, bus.cpu_rvalid, bus.rd_rvalid, bus.mem_en}, 32'd0);
        end

        // CPU store then load
        cyc();
        drive(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00);
        #1;
        chk("st_gnt",   {31'b0, bus.cpu_gnt}, 32'd1);
        chk("st_we",    {31'b0, bus.mem_we},  32'd1);
        chk("st_addr",  {26'b0, bus.mem_addr}, 32'h04);
        chk("st_wdata", bus.mem_wdata,        32'hDEADBEEF);
        cyc();
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h00);
        #1;
        chk("ld_gnt",      {31'b0, bus.cpu_gnt},    32'd1);
        chk("ld_we",       {31'b0, bus.mem_we},     32'd0);
        chk("st_norvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        #1;
        chk("ld_rvalid", {31'b0, bus.cpu_rvalid}, 32'd1);
        chk("ld_rdata",  bus.cpu_rdata,           32'hDEADBEEF);
        chk("ld_noRd",   {31'b0, bus.rd_rvalid},  32'd0);
        chk("ld_memen",  {31'b0, bus.mem_en},     32'd0);
        cyc();
        chk("ld_pulse",  {31'b0, bus.cpu_rvalid}, 32'd0);
        chk("ld_hold",   bus.cpu_rdata,           32'hDEADBEEF);

        // Readout byte select
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h10 + 8'(i));
            #1;
            chk("rd_gnt",  {31'b0, bus.rd_gnt},   32'd1);
            chk("rd_addr", {26'b0, bus.mem_addr}, 32'h04);
            if (i > 0) begin
                chk("rd_rvalid", {31'b0, bus.rd_rvalid}, 32'd1);
                chk("rd_byte",   {24'b0, bus.rd_rdata},  {24'b0, expBytes[i-1]});
            end
        end
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        #1;
        chk("rd_rvalid", {31'b0, bus.rd_rvalid},  32'd1);
        chk("rd_byte",   {24'b0, bus.rd_rdata},   32'hDE);
        chk("rd_noCpu",  {31'b0, bus.cpu_rvalid}, 32'd0);
        cyc();
        chk("rd_pulse",  {31'b0, bus.rd_rvalid}, 32'd0);
        chk("rd_hold",   {24'b0, bus.rd_rdata},  32'hDE);

        // Contention: 4 CPU grants then one forced readout grant
        for (int k = 0; k < 10; k++) begin
            cyc();
            drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 8'h12);
            #1;
            chk("cont_gnt", {30'b0, bus.cpu_gnt, bus.rd_gnt}, (k % 5 == 4) ? 32'd1 : 32'd2);
            if (k > 0) begin
                chk("cont_rsp", {30'b0, bus.cpu_rvalid, bus.rd_rvalid}, ((k - 1) % 5 == 4) ? 32'd1 : 32'd2);
                if ((k - 1) % 5 == 4) chk("cont_rdbyte", {24'b0, bus.rd_rdata}, 32'hAD);
                else                  chk("cont_cpudat", bus.cpu_rdata, 32'hDEADBEEF);
            end
        end
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        #1;
        chk("cont_last", {30'b0, bus.cpu_rvalid, bus.rd_rvalid}, 32'd1);

        // Response routing with alternating owners
        cyc();
        drive(1'b1, 1'b1, 8'h14, 32'h11223344, 1'b0, 8'h00);
        #1;
        chk("alt_st_gnt", {31'b0, bus.cpu_gnt}, 32'd1);
        prevCpu = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k % 2 == 0) drive(1'b1, 1'b0, 8'h14, 32'h0, 1'b0, 8'h00);
            else            drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h17);
            #1;
            chk("alt_gnt", {30'b0, bus.cpu_gnt, bus.rd_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 0) begin
                chk("alt_st_rsp", {30'b0, bus.cpu_rvalid, bus.rd_rvalid}, 32'd0);
            end else if (prevCpu) begin
                chk("alt_rsp_cpu", {30'b0, bus.cpu_rvalid, bus.rd_rvalid}, 32'd2);
                chk("alt_cpudat",  bus.cpu_rdata, 32'h11223344);
            end else begin
                chk("alt_rsp_rd",  {30'b0, bus.cpu_rvalid, bus.rd_rvalid}, 32'd1);
                chk("alt_rdbyte",  {24'b0, bus.rd_rdata}, 32'h11);
            end
            prevCpu = (k % 2 == 0);
        end
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        #1;
        chk("alt_last", {30'b0, bus.cpu_rvalid, bus.rd_rvalid}, 32'd1);

        // Reset in the cycle after a CPU load grant, with wait count built up
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 8'h11);
            #1;
            chk("mrst_pre_gnt", {30'b0, bus.cpu_gnt, bus.rd_gnt}, 32'd2);
        end
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        chk("mrst_rdata",  bus.cpu_rdata,           32'd0);
        cyc();
        rst = 1'b1;
        #1;
        chk("mrst_rel_gnt",    {30'b0, bus.cpu_gnt, bus.rd_gnt}, 32'd2);
        chk("mrst_rel_rvalid", {30'b0, bus.cpu_rvalid, bus.rd_rvalid}, 32'd0);
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk("mrst_gnt", {30'b0, bus.cpu_gnt, bus.rd_gnt}, (k == 4) ? 32'd1 : 32'd2);
        end
        cyc();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
